// File: rtl/clk_ratio_monitor.sv
// ---------------------------------------------------------------------------
// clk_ratio_monitor
//
// Samples the three divided clocks (clk4f, clk2f, clkf) as data on clk16f and
// checks, per channel, that every high/low run has the expected length
// (2 / 4 / 8 samples). While acquiring or locked it also checks that each
// rising clkf edge coincides with rising clk2f and clk4f edges. A three-state
// FSM (SEARCH -> ACQ -> LOCKED) declares lock after LOCK_PERIODS consecutive
// clean clkf periods. Downstream SerDes logic is gated on 'locked'.
//
// Ports
//   clk16f     : sampling clock, all inputs sampled on its rising edge
//   reset_L    : asynchronous active-low reset
//   clk4f      : divided clock under test, half-period 2 samples
//   clk2f      : divided clock under test, half-period 4 samples
//   clkf       : divided clock under test, half-period 8 samples
//   clr_err    : synchronous clear of err_flags and err_count
//   locked     : high while the lock FSM is in LOCKED (registered)
//   err_pulse  : one-cycle strobe for an error seen at the previous edge
//   err_flags  : sticky per-channel errors {clkf, clk2f, clk4f}
//   err_count  : saturating count of cycles with err_pulse high
// ---------------------------------------------------------------------------
module clk_ratio_monitor #(
    parameter int unsigned LOCK_PERIODS = 4,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk16f,
    input  logic                 reset_L,
    input  logic                 clk4f,
    input  logic                 clk2f,
    input  logic                 clkf,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [2:0]           err_flags,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_PERIODS);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX     = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE     = ERR_CNT_W'(1'b1);

    // Expected half-period per channel index (0: clk4f, 1: clk2f, 2: clkf).
    function automatic logic [3:0] half_period(input int ch);
        case (ch)
            0:       half_period = 4'd2;
            1:       half_period = 4'd4;
            2:       half_period = 4'd8;
            default: half_period = 4'd8;
        endcase
    endfunction

    logic [2:0]           sample_s;
    logic [2:0]           trans_s;
    logic [2:0]           rise_s;
    logic [2:0]           width_err_s;
    logic [2:0]           stuck_err_s;
    logic [2:0]           phase_err_s;
    logic [2:0]           err_vec_s;
    logic                 any_err_s;

    logic [2:0]           prev_q,  prev_d;
    logic [2:0]           armed_q, armed_d;
    logic [3:0]           run_q [3];
    logic [3:0]           run_d [3];
    state_t               state_q, state_d;
    logic [3:0]           periods_q, periods_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [2:0]           err_flags_q, err_flags_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    assign sample_s = {clkf, clk2f, clk4f};

    // Per-channel run-length tracking and width / stuck detection.
    always_comb begin
        prev_d      = sample_s;
        trans_s     = sample_s ^ prev_q;
        rise_s      = sample_s & ~prev_q;
        armed_d     = armed_q;
        width_err_s = 3'b000;
        stuck_err_s = 3'b000;
        for (int ch = 0; ch < 3; ch++) begin
            run_d[ch] = run_q[ch];
            if (trans_s[ch]) begin
                // The run that just ended is only judged once armed, so the
                // unknown-length first run after reset is never flagged.
                run_d[ch]       = 4'd1;
                armed_d[ch]     = 1'b1;
                width_err_s[ch] = armed_q[ch] && (run_q[ch] != half_period(ch));
            end else begin
                run_d[ch]       = (run_q[ch] == 4'd15) ? 4'd15 : run_q[ch] + 4'd1;
                // Equality (not >=) makes a stuck run report exactly once.
                stuck_err_s[ch] = armed_q[ch] && (run_q[ch] == half_period(ch));
            end
        end
    end

    // Cross-channel alignment check: a clkf rise must carry clk2f/clk4f rises.
    always_comb begin
        phase_err_s = 3'b000;
        if (((state_q == S_ACQ) || (state_q == S_LOCKED)) && rise_s[2]) begin
            phase_err_s[1] = ~rise_s[1];
            phase_err_s[0] = ~rise_s[0];
        end else begin
            phase_err_s = 3'b000;
        end
        err_vec_s = width_err_s | stuck_err_s | phase_err_s;
        any_err_s = |err_vec_s;
    end

    // Error status: a same-edge error overrides clr_err.
    always_comb begin
        err_pulse_d = any_err_s;
        err_flags_d = (clr_err ? 3'b000 : err_flags_q) | err_vec_s;
        err_count_d = err_count_q;
        if (any_err_s) begin
            if (clr_err) begin
                err_count_d = CNT_ONE;
            end else if (err_count_q == CNT_MAX) begin
                err_count_d = CNT_MAX;
            end else begin
                err_count_d = err_count_q + CNT_ONE;
            end
        end else if (clr_err) begin
            err_count_d = '0;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Lock FSM next-state; an error always wins over a qualifying clkf rise.
    always_comb begin
        state_d   = state_q;
        periods_d = periods_q;
        case (state_q)
            S_SEARCH: begin
                if (rise_s[2] && !any_err_s) begin
                    state_d   = S_ACQ;
                    periods_d = 4'd0;
                end else begin
                    state_d   = S_SEARCH;
                end
            end
            S_ACQ: begin
                if (any_err_s) begin
                    state_d = S_SEARCH;
                end else if (rise_s[2]) begin
                    periods_d = periods_q + 4'd1;
                    if ((periods_q + 4'd1) == LOCK_TARGET) begin
                        state_d = S_LOCKED;
                    end else begin
                        state_d = S_ACQ;
                    end
                end else begin
                    state_d = S_ACQ;
                end
            end
            S_LOCKED: begin
                if (any_err_s) begin
                    state_d = S_SEARCH;
                end else begin
                    state_d = S_LOCKED;
                end
            end
            default: begin
                state_d   = S_SEARCH;
                periods_d = 4'd0;
            end
        endcase
        // Decoding the next state gives a registered 'locked' that drops in
        // the same cycle err_pulse rises.
        locked_d = (state_d == S_LOCKED);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            prev_q      <= 3'b000;
            armed_q     <= 3'b000;
            for (int ch = 0; ch < 3; ch++) begin
                run_q[ch] <= 4'd0;
            end
            state_q     <= S_SEARCH;
            periods_q   <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_flags_q <= 3'b000;
            err_count_q <= '0;
        end else begin
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            for (int ch = 0; ch < 3; ch++) begin
                run_q[ch] <= run_d[ch];
            end
            state_q     <= state_d;
            periods_q   <= periods_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_flags_q <= err_flags_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_flags = err_flags_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// ---------------------------------------------------------------------------
// Directed bench for clk_ratio_monitor. One instance uses default parameters;
// a second with ERR_CNT_W=3 shares all inputs and is used for saturation.
// Ideal generator: with phase counter ph, clk4f=~ph[1], clk2f=~ph[2],
// clkf=~ph[3], so all three rise together whenever ph wraps to 0 mod 16.
// ---------------------------------------------------------------------------
module tb_clk_ratio_monitor;

    logic       clk16f  = 1'b0;
    logic       reset_L = 1'b0;
    logic       clk4f   = 1'b0;
    logic       clk2f   = 1'b0;
    logic       clkf    = 1'b0;
    logic       clr_err = 1'b0;

    logic       locked, err_pulse;
    logic [2:0] err_flags;
    logic [7:0] err_count;
    logic       locked3, err_pulse3;
    logic [2:0] err_flags3;
    logic [2:0] err_count3;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ph       = 32'd0;
    logic        saw_pulse  = 1'b0;
    logic        saw_locked = 1'b0;

    clk_ratio_monitor dut (
        .clk16f(clk16f), .reset_L(reset_L), .clk4f(clk4f), .clk2f(clk2f),
        .clkf(clkf), .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
        .err_flags(err_flags), .err_count(err_count)
    );

    clk_ratio_monitor #(.LOCK_PERIODS(4), .ERR_CNT_W(3)) dut3 (
        .clk16f(clk16f), .reset_L(reset_L), .clk4f(clk4f), .clk2f(clk2f),
        .clkf(clkf), .clr_err(clr_err), .locked(locked3), .err_pulse(err_pulse3),
        .err_flags(err_flags3), .err_count(err_count3)
    );

    always #5 clk16f = ~clk16f;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input vector for the next rising edge, then sample #1 later.
    task automatic drive(input logic c4, input logic c2, input logic cf);
        @(negedge clk16f);
        clk4f = c4;
        clk2f = c2;
        clkf  = cf;
        @(posedge clk16f);
        #1;
        if (err_pulse) saw_pulse = 1'b1;
        if (locked)    saw_locked = 1'b1;
    endtask

    task automatic step(input logic force4, input logic delay2);
        logic [31:0] pm1;
        pm1 = ph - 32'd1;
        drive(~ph[1] | force4, delay2 ? ~pm1[2] : ~ph[2], ~ph[3]);
        ph = ph + 32'd1;
    endtask

    task automatic do_reset();
        @(negedge clk16f);
        #2;
        reset_L = 1'b0;
        clk4f = 1'b0; clk2f = 1'b0; clkf = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk16f);
        @(negedge clk16f);
        reset_L    = 1'b1;
        ph         = 32'd0;
        saw_pulse  = 1'b0;
        saw_locked = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        repeat (2) @(posedge clk16f);
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_pulse",  {31'd0, err_pulse}, 32'd0);
        chk("rst_flags",  {29'd0, err_flags}, 32'd0);
        chk("rst_count",  {24'd0, err_count}, 32'd0);
        @(negedge clk16f);
        reset_L = 1'b1;

        // ---- nominal: first clkf rise at ph=0, lock after ph=64 ----
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0);
        chk("nom_locked_early", {31'd0, locked}, 32'd0);
        step(1'b0, 1'b0);
        chk("nom_locked", {31'd0, locked}, 32'd1);
        for (int i = 65; i < 500; i++) step(1'b0, 1'b0);
        chk("nom_flags", {29'd0, err_flags}, 32'd0);
        chk("nom_count", {24'd0, err_count}, 32'd0);
        chk("nom_no_pulse", {31'd0, saw_pulse}, 32'd0);
        chk("nom_still_locked", {31'd0, locked}, 32'd1);

        // ---- stuck clk4f: forced high for ph 500..505 ----
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        chk("stk_pulse1", {31'd0, err_pulse}, 32'd1);
        chk("stk_flags1", {29'd0, err_flags}, 32'd1);
        chk("stk_unlock", {31'd0, locked}, 32'd0);
        chk("stk_count1", {24'd0, err_count}, 32'd1);
        step(1'b1, 1'b0);
        chk("stk_single", {31'd0, err_pulse}, 32'd0);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        chk("stk_quiet", {31'd0, err_pulse}, 32'd0);
        step(1'b0, 1'b0);
        chk("stk_pulse2", {31'd0, err_pulse}, 32'd1);
        chk("stk_count2", {24'd0, err_count}, 32'd2);
        chk("stk_flags2", {29'd0, err_flags}, 32'd1);
        // next clean clkf rise at ph=512 -> relock after ph=576
        for (int i = 507; i < 576; i++) step(1'b0, 1'b0);
        chk("stk_relock_early", {31'd0, locked}, 32'd0);
        step(1'b0, 1'b0);
        chk("stk_relock", {31'd0, locked}, 32'd1);
        chk("stk_count_hold", {24'd0, err_count}, 32'd2);

        // ---- reset mid-lock: outputs clear without a clock edge ----
        #2;
        reset_L = 1'b0;
        clk4f = 1'b0; clk2f = 1'b0; clkf = 1'b0;
        #1;
        chk("mid_rst_locked", {31'd0, locked}, 32'd0);
        chk("mid_rst_pulse",  {31'd0, err_pulse}, 32'd0);
        chk("mid_rst_flags",  {29'd0, err_flags}, 32'd0);
        chk("mid_rst_count",  {24'd0, err_count}, 32'd0);
        repeat (3) @(posedge clk16f);
        @(negedge clk16f);
        reset_L = 1'b1;
        ph = 32'd0; saw_pulse = 1'b0; saw_locked = 1'b0;
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0);
        chk("rel_locked_early", {31'd0, locked}, 32'd0);
        step(1'b0, 1'b0);
        chk("rel_locked", {31'd0, locked}, 32'd1);
        for (int i = 65; i < 200; i++) step(1'b0, 1'b0);
        chk("rel_no_pulse", {31'd0, saw_pulse}, 32'd0);
        chk("rel_count", {24'd0, err_count}, 32'd0);

        // ---- phase shift: clk2f delayed by one sample from reset ----
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
        chk("ph_flags_before", {29'd0, err_flags}, 32'd0);
        step(1'b0, 1'b1);
        chk("ph_flags_rise", {29'd0, err_flags}, 32'd2);
        chk("ph_pulse_rise", {31'd0, err_pulse}, 32'd1);
        for (int i = 17; i < 200; i++) step(1'b0, 1'b1);
        chk("ph_never_locked", {31'd0, saw_locked}, 32'd0);
        chk("ph_flags_end", {29'd0, err_flags}, 32'd2);

        // ---- saturation: clkf stuck low, clk4f toggling every sample ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(ph[0], 1'b0, 1'b0);
            ph = ph + 32'd1;
        end
        chk("sat_count6", {29'd0, err_count3}, 32'd6);
        drive(ph[0], 1'b0, 1'b0);
        ph = ph + 32'd1;
        chk("sat_count7", {29'd0, err_count3}, 32'd7);
        for (int i = 9; i < 16; i++) begin
            drive(ph[0], 1'b0, 1'b0);
            ph = ph + 32'd1;
        end
        chk("sat_hold7", {29'd0, err_count3}, 32'd7);
        chk("sat_wide_count", {24'd0, err_count}, 32'd14);
        chk("sat_flags", {29'd0, err_flags3}, 32'd1);
        // hold clk4f high: first held sample is clean, so clr_err wins
        clr_err = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk("clr_count", {29'd0, err_count3}, 32'd0);
        chk("clr_flags", {29'd0, err_flags3}, 32'd0);
        chk("clr_pulse", {31'd0, err_pulse3}, 32'd0);
        // second held sample is a stuck error coinciding with clr_err
        drive(1'b1, 1'b0, 1'b0);
        clr_err = 1'b0;
        chk("clr_err_wins_count", {29'd0, err_count3}, 32'd1);
        chk("clr_err_wins_flags", {29'd0, err_flags3}, 32'd1);
        chk("clr_err_wins_pulse", {31'd0, err_pulse3}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

Checker and consumer of the divided clocks produced by the clock generator. Clocked by `clk16f`, it samples `clk4f`, `clk2f` and `clkf` as data and checks three things: each clock's half-period, that the clocks stay aligned to each other, and that the alignment is stable over time. It reports a lock indication and error status. It sits beside the clock generator at the PHY top and gates downstream serializer/deserializer logic on `locked`.

## Interface
- `LOCK_PERIODS`, default 4: number of consecutive error-free `clkf` periods required to declare lock (1..15).
- `ERR_CNT_W`, default 8: width of the saturating error counter.
- Reset and clock: one clock; reset is asynchronous and active-low.
- `clk16f` input 1: the single clock. All inputs are sampled on its rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `clk4f` input 1: divided clock under test. Expected high 2 / low 2 samples.
- `clk2f` input 1: divided clock under test. Expected high 4 / low 4 samples.
- `clkf` input 1: divided clock under test. Expected high 8 / low 8 samples.
- `clr_err` input 1: synchronous clear of `err_flags` and `err_count`.
- `locked` output 1: high while the lock FSM is in LOCKED.
- `err_pulse` output 1: one-cycle strobe for any error detected at the previous edge.
- `err_flags` output 3: sticky per-channel errors. Bit 0 is `clk4f`, bit 1 is `clk2f`, bit 2 is `clkf`.
- `err_count` output ERR_CNT_W: saturating count of cycles with `err_pulse` high.

## Operation
- Each channel x has an expected half-period H: 2 for `clk4f`, 4 for `clk2f`, 8 for `clkf`.
- Per-channel registers:
  - `prev_x`: last sample, resets to 0.
  - `run_x`: 4-bit run length, resets to 0, saturates at 15.
  - `armed_x`: resets to 0.
- On every edge, a transition for channel x is `in_x != prev_x`.
- On a transition:
  - `run_x <= 1`, `armed_x <= 1`.
  - If `armed_x` is already 1 and `run_x != H`, this is a width error on x.
- With no transition: `run_x <= run_x + 1` (saturating).
  - If `armed_x` is 1 and `run_x == H`, this is a stuck error on x. It fires exactly once per stuck run.
- The first run after reset is never checked, because its length is unknown.
- Phase check, active in ACQ and LOCKED only: on a rising `clkf` transition, `clk2f` and `clk4f` must also show a rising transition on that same edge.
  - A missing `clk2f` rise sets error bit 1.
  - A missing `clk4f` rise sets error bit 0.
- Any error on an edge has these effects:
  - `err_pulse` is 1 for the following cycle.
  - The matching `err_flags` bits are set.
  - `err_count` increments, saturating at 2^ERR_CNT_W−1.
- `clr_err` clears `err_flags` and `err_count` on the next edge. It has no effect on the FSM.
- If `clr_err` and an error occur on the same edge, the error wins: the flag is set and the count becomes 1.
- Lock FSM states are SEARCH, ACQ and LOCKED, with SEARCH as the reset state:
  - SEARCH: on a rising `clkf` transition with no error, go to ACQ and set `periods <= 0`.
  - ACQ: any error returns to SEARCH. Each rising `clkf` transition with no error increments `periods`. The rise that makes `periods == LOCK_PERIODS` enters LOCKED.
  - LOCKED: any error returns to SEARCH.
- `locked` is a registered decode of the state: it is 1 only in the cycle after entering LOCKED and onward.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_flags`=3'b000, `err_count`=0, state=SEARCH.
- Reset is asynchronous. Outputs clear immediately when `reset_L` falls, without waiting for a clock edge.
- Detection latency is 1 cycle: an error sampled at edge k shows as `err_pulse`/flags/count during cycle k+1.
- `locked` falls in the cycle after the offending edge, i.e. the same cycle `err_pulse` rises.
- With ideal inputs whose first `clkf` rise is at edge E0, `locked` rises after edge E0 + 16·LOCK_PERIODS (E0+64 by default).
- An error and a qualifying `clkf` rise on the same edge: the error wins, the FSM goes to SEARCH, and that rise is not used to re-enter ACQ.

## Test plan
- Nominal: ideal generator outputs released after reset. Required: `locked`=1 exactly 64 cycles after the first `clkf` rise, `err_flags`=0, `err_count`=0 for 500 cycles.
- Stuck `clk4f`: once locked, hold `clk4f` high for 6 samples. Required:
  - A single `err_pulse` in the cycle after the 3rd high sample.
  - `err_flags`=3'b001 and `locked`=0 in that same cycle.
  - A second pulse at the release edge (width 6≠2), giving `err_count`=2.
  - Relock 64+ cycles after the next clean `clkf` rise.
- Phase shift: delay `clk2f` by one `clk16f` cycle. Required:
  - `err_flags[1]` set at the next `clkf` rise.
  - `locked` never asserts afterwards.
  - Widths stay clean, so `err_flags[0]` and `err_flags[2]` remain 0.
- Reset mid-lock: assert `reset_L`=0 between edges while locked. Required: all outputs are 0 before the next edge. After release, lock is re-acquired with no errors.
- Saturation: set ERR_CNT_W=3 and force `clkf` stuck low with the other clocks wrong. Required: `err_count` reaches 7 and holds at 7. `clr_err` returns it to 0 on the next edge.
